// File: rtl/frame_gen_multi.sv
// frame_gen_multi: framed test-traffic generator (head marker, payload, tail marker)
// with runtime payload mode/length, single-word error injection and ready/valid backpressure.
module frame_gen_multi #(
  parameter int DATA_W = 10,
  parameter int LEN_W = 16,
  parameter logic [DATA_W-1:0] MARK_WORD = DATA_W'(10'b1100110011),
  parameter int POLY_LENGTH = 9,
  parameter int POLY_TAP = 5,
  parameter int INV_PATTERN = 1,
  parameter logic [POLY_LENGTH-1:0] PRBS_SEED = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_send_enable,
  input  logic [1:0]        i_mode,
  input  logic [LEN_W-1:0]  i_payload_len,
  input  logic [DATA_W-1:0] i_fixed_word,
  input  logic              i_inject_err,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_data_out,
  output logic              o_data_valid,
  output logic              o_sof,
  output logic              o_eof,
  output logic              o_busy,
  output logic [15:0]       o_frame_cnt
);
  localparam logic [1:0] IDLE = 2'd0, HEAD = 2'd1, PAYLOAD = 2'd2, TAIL = 2'd3;
  logic [1:0] r_state, r_mode;
  logic [LEN_W-1:0] r_idx, r_len;
  logic [DATA_W-1:0] r_fixed, r_walk, w_prbs_raw, w_prbs, w_payload;
  logic [POLY_LENGTH-1:0] r_lfsr, w_lfsr_next;
  logic [15:0] r_cnt;
  logic r_err_pend, r_err_act;
  logic w_b, w_acc, w_last, w_start, w_load, w_pend;
  assign w_acc = (r_state != IDLE) & i_out_ready;
  assign w_last = r_idx == r_len - LEN_W'(1);
  assign w_start = i_send_enable & ((r_state == IDLE) | ((r_state == TAIL) & w_acc));
  // a new payload word is presented after a head accept or a non-final payload accept
  assign w_load = w_acc & ((r_state == HEAD) | ((r_state == PAYLOAD) & ~w_last));
  assign w_pend = r_err_pend | i_inject_err;
  always_comb begin
    w_lfsr_next = r_lfsr;
    w_prbs_raw = '0;
    w_b = 1'b0;
    for (int k = DATA_W - 1; k >= 0; k--) begin
      w_b = w_lfsr_next[POLY_LENGTH-1] ^ w_lfsr_next[POLY_TAP-1];
      w_prbs_raw[k] = w_b;
      w_lfsr_next = {w_lfsr_next[POLY_LENGTH-2:0], w_b};
    end
  end
  assign w_prbs = (INV_PATTERN != 0) ? ~w_prbs_raw : w_prbs_raw;
  assign w_payload = (r_mode == 2'd0) ? w_prbs :
                     (r_mode == 2'd1) ? DATA_W'(r_idx) :
                     (r_mode == 2'd2) ? r_fixed : r_walk;
  assign o_data_out = (r_state == PAYLOAD) ? (w_payload ^ {{(DATA_W-1){1'b0}}, r_err_act}) :
                      (r_state == IDLE) ? '0 : MARK_WORD;
  assign o_data_valid = r_state != IDLE;
  assign o_sof = r_state == HEAD;
  assign o_eof = r_state == TAIL;
  assign o_busy = r_state != IDLE;
  assign o_frame_cnt = r_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_mode <= '0;
      r_len <= '0;
      r_idx <= '0;
      r_fixed <= '0;
      r_walk <= DATA_W'(1);
      r_lfsr <= PRBS_SEED;
      r_cnt <= '0;
      r_err_pend <= 1'b0;
      r_err_act <= 1'b0;
    end else begin
      if (w_start) begin
        r_state <= HEAD;
        r_mode <= i_mode;
        r_len <= (i_payload_len == '0) ? LEN_W'(1) : i_payload_len;
        r_fixed <= i_fixed_word;
        r_lfsr <= PRBS_SEED;
        r_idx <= '0;
        r_walk <= DATA_W'(1);
      end else if ((r_state == TAIL) & w_acc) begin
        r_state <= IDLE;
      end else if ((r_state == HEAD) & w_acc) begin
        r_state <= PAYLOAD;
      end else if ((r_state == PAYLOAD) & w_acc) begin
        r_lfsr <= w_lfsr_next;
        r_walk <= {r_walk[DATA_W-2:0], r_walk[DATA_W-1]};
        r_idx <= w_last ? '0 : r_idx + LEN_W'(1);
        r_state <= w_last ? TAIL : PAYLOAD;
      end
      if ((r_state == TAIL) & w_acc) r_cnt <= r_cnt + 16'd1;
      r_err_act <= w_load ? w_pend : (w_acc ? 1'b0 : r_err_act);
      r_err_pend <= w_load ? 1'b0 : w_pend;
    end
  end
endmodule

// File: tb/tb_frame_gen_multi.sv
// tb_frame_gen_multi: directed scoreboard bench for frame_gen_multi.
module tb_frame_gen_multi;
  logic clk = 0, rst = 1, se = 0, inj = 0, rdy = 1;
  logic [1:0] mode = 0;
  logic [15:0] len = 0;
  logic [9:0] fw = 0;
  logic [9:0] dout;
  logic dv, sof, eof, busy;
  logic [15:0] cnt;
  typedef struct packed {logic [9:0] d; logic s; logic e;} word_t;
  word_t sb[$];
  int checks = 0, errors = 0;
  int drop_at, stall_at, stall_len, inject_at, stop_at;
  always #5 clk = ~clk;
  frame_gen_multi dut (
    .clk(clk), .rst(rst), .i_send_enable(se), .i_mode(mode), .i_payload_len(len),
    .i_fixed_word(fw), .i_inject_err(inj), .i_out_ready(rdy), .o_data_out(dout),
    .o_data_valid(dv), .o_sof(sof), .o_eof(eof), .o_busy(busy), .o_frame_cnt(cnt)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cfg();
    drop_at = 1; stall_at = -1; stall_len = 3; inject_at = -1; stop_at = -1;
  endtask
  task automatic push_frame(input int m, input int n, input logic [9:0] f, input int inj_i);
    logic [8:0] s;
    logic [9:0] w;
    logic b;
    int nn;
    s = 9'h1FF;
    w = '0;
    nn = (n == 0) ? 1 : n;
    sb.push_back('{10'h333, 1'b1, 1'b0});
    for (int i = 0; i < nn; i++) begin
      case (m)
        0: for (int k = 9; k >= 0; k--) begin
             b = s[8] ^ s[4];
             s = {s[7:0], b};
             w[k] = ~b;
           end
        1: w = 10'(i);
        2: w = f;
        default: w = 10'd1 << (i % 10);
      endcase
      if (i == inj_i) w[0] = ~w[0];
      sb.push_back('{w, 1'b0, 1'b0});
    end
    sb.push_back('{10'h333, 1'b0, 1'b1});
  endtask
  task automatic drain();
    int pops = 0, bud = 0, hold = 0;
    bit seen = 0, gap = 0;
    word_t x;
    while (sb.size() > 0 && pops != stop_at && bud < 400) begin
      @(negedge clk);
      bud++;
      if (inj) inj = 0;
      if (dv && pops == inject_at) begin inj = 1; inject_at = -1; end
      if (seen && (!dv || !busy)) gap = 1;
      if (dv) seen = 1;
      if (dv && pops == stall_at) begin rdy = 0; stall_at = -1; end
      if (!rdy) begin
        hold++;
        chk("stall_valid", 32'(dv), 1);
        chk("stall_word", 32'({dout, sof, eof}), 32'(sb[0]));
        if (hold > stall_len) rdy = 1;
      end
      if (dv && rdy) begin
        x = sb.pop_front();
        chk("word", 32'({dout, sof, eof}), 32'(x));
        pops++;
        if (pops == drop_at) se = 0;
      end
    end
    chk("timeout", 32'(bud < 400), 1);
    chk("no_gap", 32'(gap), 0);
  endtask
  task automatic idle_check(input int exp_cnt);
    @(negedge clk);
    chk("idle_valid", 32'(dv), 0);
    chk("idle_busy", 32'(busy), 0);
    chk("frame_cnt", 32'(cnt), 32'(exp_cnt));
  endtask
  initial begin
    #1;
    chk("rst_data", 32'(dout), 0);
    chk("rst_valid", 32'(dv), 0);
    chk("rst_sof", 32'(sof), 0);
    chk("rst_eof", 32'(eof), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cnt", 32'(cnt), 0);
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    cfg(); mode = 1; len = 4; se = 1;
    push_frame(1, 4, 0, -1);
    drain();
    idle_check(1);
    cfg(); drop_at = 11; mode = 1; len = 3; se = 1;
    repeat (3) push_frame(1, 3, 0, -1);
    drain();
    idle_check(4);
    cfg(); stall_at = 3; mode = 1; len = 4; se = 1;
    push_frame(1, 4, 0, -1);
    drain();
    idle_check(5);
    cfg(); inject_at = 0; mode = 2; fw = 10'h155; len = 2; se = 1;
    push_frame(2, 2, 10'h155, 0);
    drain();
    idle_check(6);
    cfg(); drop_at = 11; stall_at = 15; mode = 0; len = 8; se = 1;
    repeat (2) push_frame(0, 8, 0, -1);
    drain();
    idle_check(8);
    cfg(); mode = 3; len = 12; se = 1;
    push_frame(3, 12, 0, -1);
    drain();
    idle_check(9);
    cfg(); mode = 1; len = 0; se = 1;
    push_frame(1, 0, 0, -1);
    drain();
    idle_check(10);
    cfg(); stop_at = 3; drop_at = -1; mode = 1; len = 6; se = 1;
    push_frame(1, 6, 0, -1);
    drain();
    @(posedge clk);
    #2 rst = 1;
    #1;
    chk("abort_data", 32'(dout), 0);
    chk("abort_valid", 32'(dv), 0);
    chk("abort_sof", 32'(sof), 0);
    chk("abort_eof", 32'(eof), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_cnt", 32'(cnt), 0);
    sb.delete();
    se = 0;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    cfg(); mode = 1; len = 2; se = 1;
    push_frame(1, 2, 0, -1);
    drain();
    idle_check(1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/frame_gen_multi.md
Name: frame_gen_multi

Overview:
- Parametrised successor to the single-mode frame data generator. Emits framed test traffic: head marker, N payload words, tail marker.
- Adds runtime-selectable payload mode, runtime payload length, single-word error injection, ready/valid backpressure and a completed-frame counter.
- Sits in the color-filter test path, driving the serialiser / DUT input.

Parameters:
DATA_W, 10, word width of data_out
LEN_W, 16, width of payload_len and of the internal word index
MARK_WORD, 10'b1100110011 (sized DATA_W), head and tail marker word
POLY_LENGTH, 9, LFSR length; polynomial x^POLY_LENGTH + x^POLY_TAP + 1
POLY_TAP, 5, LFSR feedback tap
INV_PATTERN, 1, 1 = invert PRBS output bits
PRBS_SEED, all ones (POLY_LENGTH bits), LFSR value loaded at frame start; must be nonzero

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
send_enable  in  1  level; request frames while high
mode  in  2  0 PRBS, 1 incrementing count, 2 fixed word, 3 walking one
payload_len  in  LEN_W  payload words per frame; 0 is treated as 1
fixed_word  in  DATA_W  payload value for mode 2
inject_err  in  1  one-cycle pulse; arms a single-word bit-0 inversion
out_ready  in  1  downstream accepts the current word
data_out  out  DATA_W  current word
data_valid  out  1  data_out is valid
sof  out  1  high while the head word is presented
eof  out  1  high while the tail word is presented
busy  out  1  state != IDLE
frame_cnt  out  16  completed frames, wraps at 2^16

Behaviour:
- Reset (async assert) clears all outputs and state:
  - data_out=0, data_valid=0, sof=0, eof=0, busy=0, frame_cnt=0.
  - State=IDLE, word index=0, LFSR=PRBS_SEED, err flags=0.
- Reset asserted mid-frame aborts the frame immediately; no tail word is emitted.
- Accept = data_valid & out_ready, sampled at the clk edge.
- While data_valid=1 and not accepted, data_out, sof and eof hold stable.
- All outputs are registered or decoded from registered state only; there is no combinational path from out_ready to data_out.
- States and transitions:
  - IDLE: data_valid=0, data_out=0. If send_enable=1, go to HEAD on the next edge.
  - Entry to HEAD latches mode, payload_len (0→1) and fixed_word, and loads LFSR=PRBS_SEED. Every PRBS frame is therefore identical.
  - HEAD: data_out=MARK_WORD, sof=1. On accept, go to PAYLOAD with index=0.
  - PAYLOAD: data_out=payload(index). On accept: if index==len-1, go to TAIL and clear index; else index+1.
  - TAIL: data_out=MARK_WORD, eof=1. On accept, frame_cnt+1, then HEAD if send_enable=1 else IDLE.
- Back-to-back frames have no idle gap.
- send_enable dropping mid-frame does not abort; the current frame completes through its tail.
- Changes to mode, payload_len or fixed_word mid-frame are ignored until the next HEAD entry.
- Latency: send_enable rising in IDLE → head word valid 1 cycle later. Minimum frame length = len+2 cycles with out_ready=1.
- Payload by mode:
  - PRBS: Fibonacci LFSR advances DATA_W steps per payload word. The first generated bit goes to the MSB. Output is inverted if INV_PATTERN=1. The LFSR advances only on accept, so a stall repeats the same word.
  - Count: payload(i) = i mod 2^DATA_W.
  - Fixed: the latched fixed_word.
  - Walking one: payload(i) = 1 << (i mod DATA_W).
- Error injection:
  - An inject_err pulse sets err_pending.
  - err_pending transfers to err_active when the next payload word is loaded: on entry to PAYLOAD or on a payload accept that is not the last word.
  - While err_active, data_out bit 0 is inverted. err_active clears on that word's accept.
  - A word that is already stalled is never modified.
  - Multiple pulses before application give a single injection.
  - Markers are never corrupted. A pending error carries into the next frame.

Test Plan:
- mode=1, len=4, send_enable held 1 cycle, out_ready=1 → data_out 0x333(sof),0,1,2,3,0x333(eof), then IDLE; frame_cnt=1.
- mode=1, len=3, send_enable held high 3 frames → 15 consecutive valid words with no gap; frame_cnt=3; busy stays high until the last tail is accepted.
- mode=1, len=4, out_ready low for 3 cycles while word 2 is presented → data_out held at 2, data_valid=1 throughout; 3 follows after ready returns.
- mode=2, fixed_word=0x155, len=2, inject_err pulsed during HEAD → payload 0x154 then 0x155; markers unchanged.
- mode=0, two consecutive frames of len=8 → identical payload sequences, matching a bench LFSR model (seed all ones, taps 9/5, inverted); a stall mid-payload does not skip any word.
- rst asserted during PAYLOAD index 2 of len=6 → all outputs 0 and frame_cnt=0 on that cycle; the next send_enable starts with a fresh head word.
